mc_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 93 +++++++++
 rtl/mc_ctrl_if.sv | 38 +++
 rtl/mc_ctrl_decode.sv | 85 ++++++++
 rtl/mc_ctrl.sv | 104 ++++++++++
 tb/tb_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcode/funct values, datapath mux codes and the control vector layout.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE_R  = 4'd2,
        S_WB_R   = 4'd3,
        S_EXE_I  = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_MEM = 4'd8,
        S_MEM_WR = 4'd9,
        S_BEQ    = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_LUI  = 2'b10;
    localparam logic [1:0] M2R_PC4  = 2'b11;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_J    = 2'b01;
    localparam logic [1:0] NPC_JR   = 2'b10;

    typedef struct packed {
        logic       PCWr;
        logic       PCWrCond;
        logic       IRWr;
        logic       MemRd;
        logic       MemWr;
        logic       RegWr;
        logic [1:0] nPc_sel;
        logic       Branch;
        logic [1:0] RegDst;
        logic [1:0] MemtoReg;
        logic       ALUsrcA;
        logic       ALUsrcB;
        logic       ExtOp;
        logic [2:0] ALUOp;
    } ctrl_t;

    // Execution state that DECODE dispatches to; S_FETCH means the
    // instruction is not one the datapath supports.
    function automatic state_t decode_target(input logic [5:0] op,
                                             input logic [5:0] funct);
        state_t t;
        t = S_FETCH;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_SLL: t = S_EXE_R;
                    FN_JR:                    t = S_JR;
                    default:                  t = S_FETCH;
                endcase
            end
            OP_ORI, OP_LUI: t = S_EXE_I;
            OP_LW, OP_SW:   t = S_ADDR;
            OP_BEQ:         t = S_BEQ;
            OP_J, OP_JAL:   t = S_JUMP;
            default:        t = S_FETCH;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// datapath control strobes, status and debug out.
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             PCWr;
    logic             PCWrCond;
    logic             IRWr;
    logic             MemRd;
    logic             MemWr;
    logic             RegWr;
    logic [1:0]       nPc_sel;
    logic             Branch;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic             ALUsrcA;
    logic             ALUsrcB;
    logic             ExtOp;
    logic [2:0]       ALUOp;
    logic             illegal;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    modport master (
        input  op, funct, mem_ready,
        output PCWr, PCWrCond, IRWr, MemRd, MemWr, RegWr, nPc_sel, Branch,
               RegDst, MemtoReg, ALUsrcA, ALUsrcB, ExtOp, ALUOp,
               illegal, instret, state
    );

    modport slave (
        output op, funct, mem_ready,
        input  PCWr, PCWrCond, IRWr, MemRd, MemWr, RegWr, nPc_sel, Branch,
               RegDst, MemtoReg, ALUsrcA, ALUsrcB, ExtOp, ALUOp,
               illegal, instret, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current state (qualified by op/funct, and by
// mem_ready only for the FETCH handshake) onto the datapath control vector.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    // Per-state control decode; everything not driven in a state stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.MemRd = 1'b1;
                o_ctrl.ALUOp = ALU_ADD;
                if (i_mem_ready) begin
                    o_ctrl.IRWr    = 1'b1;
                    o_ctrl.PCWr    = 1'b1;
                    o_ctrl.nPc_sel = NPC_PC4;
                end
            end
            S_EXE_R: begin
                case (i_funct)
                    FN_SUBU: o_ctrl.ALUOp = ALU_SUB;
                    FN_SLL: begin
                        o_ctrl.ALUOp   = ALU_SLL;
                        o_ctrl.ALUsrcA = 1'b1;
                    end
                    default: o_ctrl.ALUOp = ALU_ADD;
                endcase
            end
            S_WB_R: begin
                o_ctrl.RegWr    = 1'b1;
                o_ctrl.RegDst   = RD_RD;
                o_ctrl.MemtoReg = M2R_ALU;
            end
            S_EXE_I: begin
                o_ctrl.ALUsrcB = 1'b1;
                o_ctrl.ExtOp   = 1'b0;
                o_ctrl.ALUOp   = ALU_OR;
            end
            S_WB_I: begin
                o_ctrl.RegWr    = 1'b1;
                o_ctrl.RegDst   = RD_RT;
                o_ctrl.MemtoReg = (i_op == OP_LUI) ? M2R_LUI : M2R_ALU;
            end
            S_ADDR: begin
                o_ctrl.ALUsrcB = 1'b1;
                o_ctrl.ExtOp   = 1'b1;
                o_ctrl.ALUOp   = ALU_ADD;
            end
            S_MEM_RD: o_ctrl.MemRd = 1'b1;
            S_WB_MEM: begin
                o_ctrl.RegWr    = 1'b1;
                o_ctrl.RegDst   = RD_RT;
                o_ctrl.MemtoReg = M2R_MEM;
            end
            S_MEM_WR: o_ctrl.MemWr = 1'b1;
            S_BEQ: begin
                o_ctrl.ALUOp    = ALU_SUB;
                o_ctrl.Branch   = 1'b1;
                o_ctrl.PCWrCond = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.PCWr    = 1'b1;
                o_ctrl.nPc_sel = NPC_J;
                if (i_op == OP_JAL) begin
                    o_ctrl.RegWr    = 1'b1;
                    o_ctrl.RegDst   = RD_RA;
                    o_ctrl.MemtoReg = M2R_PC4;
                end
            end
            S_JR: begin
                o_ctrl.PCWr    = 1'b1;
                o_ctrl.nPc_sel = NPC_JR;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing,
// sticky illegal-opcode flag and retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_if.master     bus
);

    state_t             r_state;
    state_t             w_next;
    logic               r_illegal;
    logic               w_set_illegal;
    logic               w_retire;
    logic [CNT_W-1:0]   r_instret;
    ctrl_t              w_ctrl;
    ctrl_t              w_out;

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_op        (bus.op),
        .i_funct     (bus.funct),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Next-state sequencing plus retire / illegal-opcode events.
    always_comb begin
        w_next        = S_FETCH;
        w_set_illegal = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                w_next        = decode_target(bus.op, bus.funct);
                w_set_illegal = (w_next == S_FETCH);
            end
            S_EXE_R:  w_next = S_WB_R;
            S_EXE_I:  w_next = S_WB_I;
            S_ADDR:   w_next = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: w_next = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: begin
                w_next   = bus.mem_ready ? S_FETCH : S_MEM_WR;
                w_retire = bus.mem_ready;
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BEQ, S_JUMP, S_JR: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            default:  w_next = S_FETCH;
        endcase
    end

    // State register; an asynchronous reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky illegal flag and wrapping retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // While reset is held, the FETCH decode must not leak a read request.
    always_comb begin
        w_out = rst_n ? w_ctrl : '0;
    end

    assign bus.PCWr     = w_out.PCWr;
    assign bus.PCWrCond = w_out.PCWrCond;
    assign bus.IRWr     = w_out.IRWr;
    assign bus.MemRd    = w_out.MemRd;
    assign bus.MemWr    = w_out.MemWr;
    assign bus.RegWr    = w_out.RegWr;
    assign bus.nPc_sel  = w_out.nPc_sel;
    assign bus.Branch   = w_out.Branch;
    assign bus.RegDst   = w_out.RegDst;
    assign bus.MemtoReg = w_out.MemtoReg;
    assign bus.ALUsrcA  = w_out.ALUsrcA;
    assign bus.ALUsrcB  = w_out.ALUsrcB;
    assign bus.ExtOp    = w_out.ExtOp;
    assign bus.ALUOp    = w_out.ALUOp;
    assign bus.illegal  = r_illegal;
    assign bus.instret  = r_instret;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table of instructions with hand-derived control vectors,
// a completion scoreboard, and hand sequences for reset and stall corners.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) bus ();
    mc_ctrl_if #(.CNT_W(3))  bus3 ();

    assign bus3.op        = bus.op;
    assign bus3.funct     = bus.funct;
    assign bus3.mem_ready = bus.mem_ready;

    mc_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mc_ctrl #(.CNT_W(3))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Observed control vector:
    // {PCWr,PCWrCond,IRWr,MemRd,MemWr,RegWr,nPc_sel,Branch,RegDst,MemtoReg,ALUsrcA,ALUsrcB,ExtOp,ALUOp}
    logic [18:0] obs;
    assign obs = {bus.PCWr, bus.PCWrCond, bus.IRWr, bus.MemRd, bus.MemWr, bus.RegWr,
                  bus.nPc_sel, bus.Branch, bus.RegDst, bus.MemtoReg,
                  bus.ALUsrcA, bus.ALUsrcB, bus.ExtOp, bus.ALUOp};

    function automatic logic [18:0] cv(input logic pcwr, input logic pcwrc, input logic irwr,
                                       input logic memrd, input logic memwr, input logic regwr,
                                       input logic [1:0] npc, input logic br,
                                       input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic asa, input logic asb, input logic ext,
                                       input logic [2:0] aop);
        return {pcwr, pcwrc, irwr, memrd, memwr, regwr, npc, br, rd, m2r, asa, asb, ext, aop};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        int          fw;     // FETCH cycles with mem_ready low
        int          w;      // MEM_RD/MEM_WR cycles with mem_ready low
        int          cyc;    // expected cycles FETCH..last state
        int          mw;     // expected cycles with MemWr high
        int          rw;     // expected cycles with RegWr high
        bit          ret;
        bit          ill;
        state_t      key;
        logic [18:0] kv;
    } vec_t;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] instret;
        bit          ill;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_instret;
    bit          exp_ill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] funct,
                       input int fw, input int w, input int cyc, input int mw, input int rw,
                       input bit ret, input bit ill, input state_t key, input logic [18:0] kv);
        vec_t v;
        v.name = nm; v.op = op; v.funct = funct; v.fw = fw; v.w = w; v.cyc = cyc;
        v.mw = mw; v.rw = rw; v.ret = ret; v.ill = ill; v.key = key; v.kv = kv;
        tbl.push_back(v);
    endtask

    // Completion monitor: an instruction ends when the FSM re-enters FETCH.
    int     mon_cnt;
    state_t mon_prev;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_cnt  = 0;
            mon_prev = S_FETCH;
        end else begin
            mon_cnt++;
            if (mon_prev != S_FETCH && bus.state == S_FETCH) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_cycles"}, 32'(mon_cnt - 1), 32'(e.cyc));
                    chk({e.name, "_instret"}, bus.instret, e.instret);
                    chk({e.name, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
                    chk({e.name, "_instret3"}, 32'(bus3.instret), {29'd0, e.instret[2:0]});
                end
                mon_cnt = 1;
            end
            mon_prev = state_t'(bus.state);
        end
    end

    // Drives one instruction; must be entered at a falling edge while in FETCH.
    task automatic run(input vec_t v);
        int   fcnt, wcnt, mw, rw;
        bit   seen, done, keyd;
        exp_t e;
        fcnt = 0; wcnt = 0; mw = 0; rw = 0; seen = 0; done = 0; keyd = 0;
        bus.op    = v.op;
        bus.funct = v.funct;
        if (v.ret) exp_instret = exp_instret + 32'd1;
        if (v.ill) exp_ill = 1'b1;
        e.name = v.name; e.cyc = v.cyc; e.instret = exp_instret; e.ill = exp_ill;
        sb.push_back(e);
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (seen && bus.state == S_FETCH) begin
                done = 1;
                break;
            end
            if (bus.state != S_FETCH) seen = 1;
            if (bus.state == S_FETCH && fcnt < v.fw) begin
                bus.mem_ready = 1'b0;
                fcnt++;
            end else if ((bus.state == S_MEM_RD || bus.state == S_MEM_WR) && wcnt < v.w) begin
                bus.mem_ready = 1'b0;
                wcnt++;
            end else if (bus.state == S_FETCH || bus.state == S_MEM_RD || bus.state == S_MEM_WR) begin
                bus.mem_ready = 1'b1;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.MemWr) mw++;
            if (bus.RegWr) rw++;
            if (!keyd && bus.state == v.key) begin
                keyd = 1;
                chk({v.name, "_ctl"}, 32'(obs), 32'(v.kv));
            end
        end
        chk({v.name, "_finished"}, 32'(done), 32'd1);
        chk({v.name, "_keystate_seen"}, 32'(keyd), 32'd1);
        chk({v.name, "_memwr_cycles"}, 32'(mw), 32'(v.mw));
        chk({v.name, "_regwr_cycles"}, 32'(rw), 32'(v.rw));
        bus.mem_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst_n = 1'b0;
        bus.op = 6'd0; bus.funct = 6'd0; bus.mem_ready = 1'b0;
        exp_instret = 32'd0;
        exp_ill = 1'b0;

        //   name      op         funct      fw w  cyc mw rw ret ill key       control vector in key state
        add("addu",   6'b000000, 6'b100001, 0, 0, 4, 0, 1, 1, 0, S_WB_R,   cv(0,0,0,0,0,1,2'b00,0,2'b01,2'b00,0,0,0,3'b000));
        add("subu",   6'b000000, 6'b100011, 0, 0, 4, 0, 1, 1, 0, S_EXE_R,  cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,3'b001));
        add("sll",    6'b000000, 6'b000000, 0, 0, 4, 0, 1, 1, 0, S_EXE_R,  cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,3'b011));
        add("ori",    6'b001101, 6'b010101, 2, 0, 6, 0, 1, 1, 0, S_EXE_I,  cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,0,3'b010));
        add("lui",    6'b001111, 6'b000000, 0, 0, 4, 0, 1, 1, 0, S_WB_I,   cv(0,0,0,0,0,1,2'b00,0,2'b00,2'b10,0,0,0,3'b000));
        add("lw_w3",  6'b100011, 6'b000000, 0, 3, 8, 0, 1, 1, 0, S_WB_MEM, cv(0,0,0,0,0,1,2'b00,0,2'b00,2'b01,0,0,0,3'b000));
        add("sw_w2",  6'b101011, 6'b000000, 0, 2, 6, 3, 0, 1, 0, S_ADDR,   cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,3'b000));
        add("beq",    6'b000100, 6'b000000, 0, 0, 3, 0, 0, 1, 0, S_BEQ,    cv(0,1,0,0,0,0,2'b00,1,2'b00,2'b00,0,0,0,3'b001));
        add("jal",    6'b000011, 6'b000000, 0, 0, 3, 0, 1, 1, 0, S_JUMP,   cv(1,0,0,0,0,1,2'b01,0,2'b10,2'b11,0,0,0,3'b000));
        add("j",      6'b000010, 6'b000000, 0, 0, 3, 0, 0, 1, 0, S_JUMP,   cv(1,0,0,0,0,0,2'b01,0,2'b00,2'b00,0,0,0,3'b000));
        add("ill_op", 6'b111111, 6'b000000, 0, 0, 2, 0, 0, 0, 1, S_DECODE, cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,3'b000));
        add("jr",     6'b000000, 6'b001000, 0, 0, 3, 0, 0, 1, 1, S_JR,     cv(1,0,0,0,0,0,2'b10,0,2'b00,2'b00,0,0,0,3'b000));
        add("ill_fn", 6'b000000, 6'b101010, 0, 0, 2, 0, 0, 0, 1, S_DECODE, cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,3'b000));
        add("lw_w0",  6'b100011, 6'b000000, 0, 0, 5, 0, 1, 1, 1, S_MEM_RD, cv(0,0,0,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,3'b000));
        add("sw_w0",  6'b101011, 6'b000000, 0, 0, 4, 1, 0, 1, 1, S_MEM_WR, cv(0,0,0,0,1,0,2'b00,0,2'b00,2'b00,0,0,0,3'b000));
        add("addu2",  6'b000000, 6'b100001, 0, 0, 4, 0, 1, 1, 1, S_EXE_R,  cv(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,3'b000));

        // Power-on reset state
        #12;
        chk("rst_state", 32'(bus.state), 32'(S_FETCH));
        chk("rst_ctl", 32'(obs), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);

        // One retire, then reset while a lw waits in MEM_RD
        run(tbl[0]);
        bus.op = OP_LW; bus.funct = 6'd0; bus.mem_ready = 1'b1;
        hit = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.state == S_MEM_RD) begin
                hit = 1;
                break;
            end
        end
        bus.mem_ready = 1'b0;
        #1;
        chk("midrst_reached_memrd", 32'(hit), 32'd1);
        chk("midrst_memrd_before", 32'(bus.MemRd), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 32'(obs), 32'd0);
        chk("midrst_state", 32'(bus.state), 32'(S_FETCH));
        chk("midrst_instret", bus.instret, 32'd0);
        exp_instret = 32'd0;
        exp_ill = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("postrst_state", 32'(bus.state), 32'(S_FETCH));
        chk("postrst_memrd", 32'(bus.MemRd), 32'd1);

        // Table-driven instruction stream
        foreach (tbl[i]) begin
            run(tbl[i]);
            if (exp_instret == 32'd8) chk("instret3_wrap", 32'(bus3.instret), 32'd0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_instret", bus.instret, exp_instret);
        chk("final_illegal", 32'(bus.illegal), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
